// File: rtl/mul_unit_pkg.sv
// Shared processor package: multiplier width constants and FSM state type.
package mul_unit_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 4;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_unit_if.sv
// Issue/writeback bundle between the core and the multiply unit.
interface mul_unit_if;
  import mul_unit_pkg::*;

  logic              start;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] acc;
  logic              accumulate;
  logic [RD_W-1:0]   rd_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [RD_W-1:0]   rd_out;
  logic              we_out;
  logic              n_flag;
  logic              z_flag;

  modport master (
    output start, op_a, op_b, acc, accumulate, rd_in,
    input  busy, done, result, rd_out, we_out, n_flag, z_flag
  );

  modport slave (
    input  start, op_a, op_b, acc, accumulate, rd_in,
    output busy, done, result, rd_out, we_out, n_flag, z_flag
  );

endinterface

// File: rtl/mul_unit.sv
// Iterative 32x32 shift-add multiplier (MUL / MLA), fixed 33-cycle latency,
// results truncated modulo 2^32.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input logic      clk,
  input logic      rst,
  mul_unit_if.slave bus
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   psum;
  logic [WIDTH-1:0]   psum_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   result_q;
  logic [RD_W-1:0]    rd_q;
  logic               n_q;
  logic               z_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: RUN lasts exactly 32 cycles, DONE exactly one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == '1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    psum_nxt = psum;
    if (mplier[0]) psum_nxt = psum + mcand;
  end

  // Datapath: operand latch on accept, iterate in RUN, capture result on the last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand    <= '0;
      mplier   <= '0;
      psum     <= '0;
      cnt      <= '0;
      result_q <= '0;
      rd_q     <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.op_a;
            mplier <= bus.op_b;
            psum   <= bus.accumulate ? bus.acc : '0;
            cnt    <= '0;
            rd_q   <= bus.rd_in;
          end
        end
        RUN: begin
          psum   <= psum_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Result and flags are registered separately so they stay stable
          // through the following IDLE period until the next accepted start.
          if (cnt == '1) begin
            result_q <= psum_nxt;
            n_q      <= psum_nxt[WIDTH-1];
            z_q      <= (psum_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Status and writeback outputs.
  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done   = (state == DONE);
    bus.we_out = (state == DONE);
    bus.result = result_q;
    bus.rd_out = rd_q;
    bus.n_flag = n_q;
    bus.z_flag = z_q;
  end

endmodule

// File: doc/mul_unit.md
MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port: op_a  input  32  multiplicand, driven from register-file RD1.
REQ-006 SHALL have port: op_b  input  32  multiplier, driven from register-file RD2.
REQ-007 SHALL have port: acc  input  32  accumulate addend for MLA.
REQ-008 SHALL have port: accumulate  input  1  1 = MLA (a*b+acc), 0 = MUL (a*b).
REQ-009 SHALL have port: rd_in  input  4  destination register index.
REQ-010 SHALL have port: busy  output  1  high while not IDLE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse: result valid.
REQ-012 SHALL have port: result  output  32  product, feeds register-file WD3.
REQ-013 SHALL have port: rd_out  output  4  latched rd_in, feeds register-file A3.
REQ-014 SHALL have port: we_out  output  1  equals done, feeds register-file WE3.
REQ-015 SHALL have port: n_flag, z_flag  output  1 each  result[31] and (result==0), valid with done.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE.
REQ-017 SHALL, in IDLE with start=1 at an edge, latch op_a, op_b, rd_in, and accumulate; load the partial sum with acc when accumulate=1, else with 0; clear the 5-bit counter; go to RUN.
REQ-018 SHALL, in RUN, each cycle add the shifted multiplicand to the partial sum when the current multiplier LSB is 1, then shift the multiplicand left 1 and the multiplier right 1 (shift-add, LSB first).
REQ-019 SHALL, in RUN, increment the counter each cycle and go to DONE after the 32nd RUN cycle (counter==31).
REQ-020 SHALL hold done=we_out=1 for exactly the single DONE cycle, then return to IDLE.
REQ-021 SHALL make done high in the 33rd cycle after the start-sampling edge: fixed latency, no early termination.
REQ-022 SHALL compute all arithmetic modulo 2^32: result = (op_a*op_b [+acc]) mod 2^32; high product bits are discarded; there is no overflow output.
REQ-023 SHALL treat operands as unsigned; the low 32 bits equal the signed result.
REQ-024 SHALL ignore start while busy=1; latched operands are not disturbed.
REQ-025 SHALL hold result, rd_out, n_flag, and z_flag stable from DONE until the next accepted start.
REQ-026 SHALL accept start in the IDLE cycle directly after DONE (back-to-back issue).
REQ-027 SHALL keep we_out low in every state except DONE.

Reset
REQ-028 SHALL, on rst=0 at any time including mid-RUN, force state IDLE, counter 0, and result, rd_out, busy, done, we_out, n_flag, z_flag all to 0.
REQ-029 SHALL emit no done for an operation aborted by reset.
REQ-030 SHALL not accept start in the same edge where rst is released; the first start is sampled at the following edge.

Structure
REQ-031 SHALL place the state enum type (IDLE/RUN/DONE) and the WIDTH constant in a shared processor package.
REQ-032 SHALL be a single module with no sub-module; datapath and FSM are in one file.

Verification
REQ-033 SHALL cover MUL: op_a=3, op_b=5, rd_in=2, start 1 cycle -> busy for 33 cycles, done with result=0x0000000F, rd_out=2, we_out=1, z=0, n=0.
REQ-034 SHALL cover MLA: op_a=0x10, op_b=0x10, acc=1, accumulate=1 -> result=0x00000101.
REQ-035 SHALL cover wrap: op_a=op_b=0xFFFFFFFF, MUL -> result=0x00000001; then op_a=0x80000000, op_b=1 -> result=0x80000000, n_flag=1.
REQ-036 SHALL cover zero and busy: op_a=0, op_b=0x1234 -> z_flag=1; a second start pulse with different operands at cycle 10 of RUN -> ignored, result unchanged, exactly one done.
REQ-037 SHALL cover reset mid-op: start 7*9, rst=0 at RUN cycle 15 -> all outputs 0 immediately, no done; after release, start 7*9 -> result=0x0000003F.
REQ-038 SHALL cover back-to-back: start 2*2 then start asserted in the IDLE cycle after DONE with 3*3 -> done pulses carrying 4 then 9, 34 cycles apart.
